// File: rtl/result_monitor.sv
// result_monitor: checks writes on a monitored port against an expected-value table.
// Define RESULT_MONITOR_TIMEOUT_EN to add a CHECK-state watchdog driving timeout.
module result_monitor #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter int CHECK_NUM = 33,
  parameter logic [ADDR_W-1:0] TEST_PORT = 30'h40,
  parameter logic [DATA_W-1:0] BEGIN_SYM = 32'h00000932,
  parameter int ERR_W = 8,
  parameter int DUR_W = 16,
  parameter int TIMEOUT = 16'hFFFF,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  input  logic              ld_en,
  input  logic [IW-1:0]     ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              stop_on_err,
  input  logic              clear,
  output logic [ERR_W-1:0]  error_num,
  output logic [DUR_W-1:0]  duration,
  output logic              finish,
  output logic              busy,
  output logic              fail_valid,
  output logic [IW-1:0]     fail_idx,
  output logic              timeout
);
  localparam logic [1:0] IDLE = 2'd0, CHECK = 2'd1, REPORT = 2'd2;
  localparam logic [ERR_W-1:0] ERR_MAX = {{(ERR_W-1){1'b1}}, 1'b0};
  localparam logic [IW-1:0] LAST_IDX = IW'(CHECK_NUM - 1);
  logic [1:0] state;
  logic [IW-1:0] idx;
  logic prev_wen, acc, mis, last, to_hit, done;
  logic [DATA_W-1:0] tbl [DEPTH];
  // Edge-qualified accept: a stalled bus holding wen counts once.
  assign acc = wen && addr == TEST_PORT && !prev_wen;
  assign mis = acc && data != tbl[idx];
  assign last = acc && idx == LAST_IDX;
  assign done = last || (stop_on_err && mis) || to_hit;
  assign busy = state == CHECK;
  assign finish = state == REPORT;
  always_ff @(posedge clk)
    if (ld_en) tbl[ld_idx] <= ld_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      prev_wen <= 1'b0;
      error_num <= '1;
      duration <= '0;
      fail_valid <= 1'b0;
      fail_idx <= '0;
    end else if (clear) begin
      state <= IDLE;
      idx <= '0;
      prev_wen <= 1'b0;
      error_num <= '1;
      duration <= '0;
      fail_valid <= 1'b0;
      fail_idx <= '0;
    end else begin
      prev_wen <= wen;
      if (state == IDLE && acc && data == BEGIN_SYM) begin
        state <= CHECK;
        idx <= '0;
        error_num <= '0;
        duration <= '0;
        fail_valid <= 1'b0;
        fail_idx <= '0;
      end else if (state == CHECK) begin
        duration <= &duration ? duration : duration + DUR_W'(1);
        if (acc) idx <= idx + IW'(1);
        if (mis && error_num != ERR_MAX) error_num <= error_num + ERR_W'(1);
        if (mis && !fail_valid) begin
          fail_valid <= 1'b1;
          fail_idx <= idx;
        end
        if (done) state <= REPORT;
      end
    end
`ifdef RESULT_MONITOR_TIMEOUT_EN
  logic [31:0] wd;
  assign to_hit = state == CHECK && wd == 32'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wd <= '0;
      timeout <= 1'b0;
    end else if (clear) begin
      wd <= '0;
      timeout <= 1'b0;
    end else begin
      wd <= state == CHECK ? wd + 32'd1 : '0;
      if (to_hit && !last && !(stop_on_err && mis)) timeout <= 1'b1;
    end
`else
  assign to_hit = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_result_monitor.sv
// tb_result_monitor: randomized scenarios for result_monitor checked against a per-run behavioural model.
module tb_result_monitor;
  localparam int ERR_W = 4, DEPTH = 64, CHECK_NUM = 33, SAT = (1 << ERR_W) - 2;
  localparam logic [29:0] TP = 30'h40, NOISE_PORT = 30'h44;
  localparam logic [31:0] BEGIN_SYM = 32'h00000932;
  logic clk = 1'b0, rst = 1'b1;
  logic [29:0] addr;
  logic [31:0] data, ld_data;
  logic wen, ld_en, stop_on_err, clear;
  logic [5:0] ld_idx, fail_idx;
  logic [ERR_W-1:0] error_num;
  logic [15:0] duration;
  logic finish, busy, fail_valid, timeout;
  int cyc = 0, ncmp = 0, nbad = 0;
  logic [31:0] exp_tbl [DEPTH];

  result_monitor #(.ERR_W(ERR_W), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .stop_on_err(stop_on_err), .clear(clear),
    .error_num(error_num), .duration(duration), .finish(finish), .busy(busy),
    .fail_valid(fail_valid), .fail_idx(fail_idx), .timeout(timeout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic wr(input logic [29:0] a, input logic [31:0] d, input int hold, input int gap,
                    input bit ld, input int li, input logic [31:0] lv, output int ac);
    @(negedge clk);
    addr = a; data = d; wen = 1'b1; ld_en = ld; ld_idx = 6'(li); ld_data = lv;
    ac = cyc + 1;
    @(negedge clk);
    ld_en = 1'b0;
    repeat (hold - 1) @(negedge clk);
    wen = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic load(input bit fib);
    for (int i = 0; i < DEPTH; i++) begin
      exp_tbl[i] = fib ? (i < 2 ? 32'(i) : exp_tbl[i-1] + exp_tbl[i-2]) : $urandom;
      @(negedge clk);
      ld_en = 1'b1; ld_idx = 6'(i); ld_data = exp_tbl[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic run(input string nm, input bit fib, input bit stop, input logic [63:0] bad,
                     input int hold, input bit noise, input bit collide);
    int ac, b, last_c, i, errs, first, h;
    bit done, m;
    logic [31:0] d, e;
    load(fib);
    stop_on_err = stop;
    wr(TP, BEGIN_SYM, 1, 1, 1'b0, 0, 32'h0, b);
    ncmp++;
    if (busy !== 1'b1) begin nbad++; $display("FAIL %s busy after begin got %0b want 1", nm, busy); end
    i = 0; errs = 0; first = -1; done = 1'b0; last_c = b;
    for (int k = 0; k < CHECK_NUM + 2; k++) begin
      h = hold > 0 ? hold : int'($urandom_range(1, 4));
      if (noise && $urandom_range(0, 1) == 1)
        wr(NOISE_PORT, $urandom, h, int'($urandom_range(1, 3)), 1'b0, 0, 32'h0, ac);
      e = exp_tbl[k];
      d = bad[k] ? e + 32'd94 : e;
      wr(TP, d, h, int'($urandom_range(1, 3)), collide && k == 3, k, e ^ 32'h1, ac);
      if (!done) begin
        m = d != exp_tbl[i];
        if (m) begin errs++; if (first < 0) first = i; end
        i++;
        last_c = ac;
        done = i == CHECK_NUM || (stop && m);
      end
      if (collide && k == 3) exp_tbl[3] = e ^ 32'h1;
    end
    repeat (2) @(negedge clk);
    ncmp++;
    if (finish !== 1'b1 || busy !== 1'b0) begin nbad++; $display("FAIL %s state got finish=%0b busy=%0b want 1/0", nm, finish, busy); end
    ncmp++;
    if (error_num !== ERR_W'(errs > SAT ? SAT : errs)) begin nbad++; $display("FAIL %s error_num got %0d want %0d", nm, error_num, errs > SAT ? SAT : errs); end
    ncmp++;
    if (fail_valid !== (first >= 0)) begin nbad++; $display("FAIL %s fail_valid got %0b want %0b", nm, fail_valid, first >= 0); end
    if (first >= 0) begin
      ncmp++;
      if (fail_idx !== 6'(first)) begin nbad++; $display("FAIL %s fail_idx got %0d want %0d", nm, fail_idx, first); end
    end
    ncmp++;
    if (duration !== 16'(last_c - b)) begin nbad++; $display("FAIL %s duration got %0d want %0d", nm, duration, last_c - b); end
    ncmp++;
    if (timeout !== 1'b0) begin nbad++; $display("FAIL %s timeout got %0b want 0", nm, timeout); end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    ncmp++;
    if ({busy, finish, fail_valid, timeout} !== 4'b0 || error_num !== '1 || duration !== 16'h0 || fail_idx !== 6'h0) begin
      nbad++; $display("FAIL reset got busy=%0b finish=%0b fv=%0b to=%0b err=%0h dur=%0d fidx=%0d want 0/0/0/0/f/0/0",
                       busy, finish, fail_valid, timeout, error_num, duration, fail_idx);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle();
    int ac;
    wr(TP, BEGIN_SYM ^ 32'h1, 1, 1, 1'b0, 0, 32'h0, ac);
    wr(NOISE_PORT, BEGIN_SYM, 1, 2, 1'b0, 0, 32'h0, ac);
    ncmp++;
    if (busy !== 1'b0 || error_num !== '1) begin nbad++; $display("FAIL idle_ignore got busy=%0b err=%0h want 0/f", busy, error_num); end
  endtask

  task automatic test_clear();
    int ac;
    run("clear_pre", 1'b1, 1'b0, 64'h20, 1, 1'b0, 1'b0);
    pulse_clear();
    ncmp++;
    if ({busy, finish, fail_valid, timeout} !== 4'b0 || error_num !== '1 || duration !== 16'h0 || fail_idx !== 6'h0) begin
      nbad++; $display("FAIL clear_report got busy=%0b finish=%0b fv=%0b err=%0h dur=%0d fidx=%0d want 0/0/0/f/0/0",
                       busy, finish, fail_valid, error_num, duration, fail_idx);
    end
    wr(TP, BEGIN_SYM, 1, 1, 1'b0, 0, 32'h0, ac);
    wr(TP, 32'hdead, 1, 1, 1'b0, 0, 32'h0, ac);
    pulse_clear();
    ncmp++;
    if (busy !== 1'b0 || error_num !== '1 || fail_valid !== 1'b0) begin
      nbad++; $display("FAIL clear_check got busy=%0b err=%0h fv=%0b want 0/f/0", busy, error_num, fail_valid);
    end
  endtask

  task automatic test_reset_mid();
    int ac;
    load(1'b1);
    wr(TP, BEGIN_SYM, 1, 1, 1'b0, 0, 32'h0, ac);
    for (int k = 0; k < 3; k++) wr(TP, k == 1 ? 32'd77 : exp_tbl[k], 1, 1, 1'b0, 0, 32'h0, ac);
    ncmp++;
    if (fail_valid !== 1'b1 || busy !== 1'b1) begin nbad++; $display("FAIL rst_mid_pre got fv=%0b busy=%0b want 1/1", fail_valid, busy); end
    #2 rst = 1'b0;
    #1;
    ncmp++;
    if ({busy, finish, fail_valid, timeout} !== 4'b0 || error_num !== '1 || duration !== 16'h0 || fail_idx !== 6'h0) begin
      nbad++; $display("FAIL rst_mid got busy=%0b finish=%0b fv=%0b err=%0h dur=%0d fidx=%0d want 0/0/0/f/0/0",
                       busy, finish, fail_valid, error_num, duration, fail_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    run("rst_fresh", 1'b1, 1'b0, 64'h0, 1, 1'b0, 1'b0);
    pulse_clear();
  endtask

  task automatic test_timeout();
    int b;
    wr(TP, BEGIN_SYM, 1, 1, 1'b0, 0, 32'h0, b);
`ifdef RESULT_MONITOR_TIMEOUT_EN
    repeat (105) @(negedge clk);
    ncmp++;
    if (timeout !== 1'b1 || finish !== 1'b1 || duration !== 16'd100) begin
      nbad++; $display("FAIL timeout got to=%0b finish=%0b dur=%0d want 1/1/100", timeout, finish, duration);
    end
`else
    repeat (120) @(negedge clk);
    ncmp++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      nbad++; $display("FAIL no_watchdog got to=%0b busy=%0b want 0/1", timeout, busy);
    end
`endif
    pulse_clear();
  endtask

  initial begin
    addr = '0; data = '0; wen = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    stop_on_err = 1'b0; clear = 1'b0;
    test_reset();
    test_idle();
    run("match", 1'b1, 1'b0, 64'h0, 1, 1'b0, 1'b0);
    pulse_clear();
    run("mismatch5", 1'b1, 1'b0, 64'h20, 1, 1'b0, 1'b0);
    pulse_clear();
    run("stop5", 1'b1, 1'b1, 64'h20, 1, 1'b0, 1'b0);
    pulse_clear();
    run("stall", 1'b1, 1'b0, 64'h0, 4, 1'b1, 1'b0);
    pulse_clear();
    run("saturate", 1'b0, 1'b0, '1, 1, 1'b0, 1'b0);
    pulse_clear();
    for (int r = 0; r < 4; r++) begin
      run("random", 1'b0, 1'($urandom_range(0, 1)),
          {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}, 0, 1'b1, 1'b1);
      pulse_clear();
    end
    test_clear();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/result_monitor.md
RESULT_MONITOR -- requirements
Module: result_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, 30, monitored bus address width.
REQ-002 SHALL have parameter DATA_W, 32, monitored bus data width.
REQ-003 SHALL have parameter DEPTH, 64, number of expected-value table entries (power of 2).
REQ-004 SHALL have parameter CHECK_NUM, 33, number of accepted writes checked per run (1..DEPTH).
REQ-005 SHALL have parameter TEST_PORT, 30'h40, monitored word address.
REQ-006 SHALL have parameter BEGIN_SYM, 32'h00000932, data value that starts a run.
REQ-007 SHALL have parameters ERR_W, 8, and DUR_W, 16, giving the error-counter and duration-counter widths.
REQ-008 SHALL have parameter TIMEOUT, 16'hFFFF, watchdog limit in cycles (used only per REQ-027).
REQ-009 SHALL have ports: clk in 1, sole clock; rst in 1, asynchronous active-low reset.
REQ-010 SHALL have ports: addr in ADDR_W, data in DATA_W, wen in 1; monitored write bus.
REQ-011 SHALL have ports: ld_en in 1, ld_idx in log2(DEPTH), ld_data in DATA_W; expected-table load port.
REQ-012 SHALL have ports: stop_on_err in 1, end run at first mismatch; clear in 1, synchronous return to idle.
REQ-013 SHALL have ports: error_num out ERR_W; duration out DUR_W; finish out 1; busy out 1.
REQ-014 SHALL have ports: fail_valid out 1, fail_idx out log2(DEPTH) (first mismatch index); timeout out 1.

Function
REQ-015 SHALL implement states IDLE, CHECK, REPORT; busy=1 only in CHECK; finish=1 only in REPORT.
REQ-016 SHALL accept a write only when wen=1, addr==TEST_PORT and wen was 0 in the previous cycle; a wen held high for N cycles counts once, in every state.
REQ-017 In IDLE, an accepted write with data==BEGIN_SYM SHALL move to CHECK next cycle, set error_num=0, duration=0, index=0, fail_valid=0; other writes ignored.
REQ-018 In CHECK, each accepted write SHALL compare data against table[index], then increment index; BEGIN_SYM is treated as ordinary data.
REQ-019 On mismatch, error_num SHALL increment next cycle, saturating at 2^ERR_W-2 (all-ones reserved for "not started").
REQ-020 On the first mismatch of a run, fail_idx SHALL capture index and fail_valid SHALL rise next cycle, both held until the next run starts.
REQ-021 duration SHALL increment every CHECK cycle, saturating at all-ones, and hold in REPORT.
REQ-022 CHECK SHALL go to REPORT in the cycle after the CHECK_NUM-th accepted write, or after the first mismatch when stop_on_err=1.
REQ-023 REPORT SHALL hold all outputs until clear or reset; accepted writes there are ignored.
REQ-024 clear=1 SHALL, next cycle, force IDLE and the reset values of REQ-026 (table untouched), with priority over every other event.
REQ-025 ld_en=1 SHALL write ld_data to table[ld_idx] in any state; a same-cycle compare of that entry SHALL use the old value.

Reset
REQ-026 rst low SHALL asynchronously force IDLE, error_num=all-ones, duration=0, finish=0, busy=0, fail_valid=0, fail_idx=0, timeout=0, index=0, previous-wen=0; table contents undefined.

Configuration
REQ-027 With RESULT_MONITOR_TIMEOUT_EN defined, a CHECK run reaching TIMEOUT cycles without completing SHALL go to REPORT next cycle with timeout=1 held until clear/reset; without it, timeout is tied 0 and no watchdog counter exists.

Verification
REQ-028 Load table 0,1,1,2..., write BEGIN_SYM to 0x40, then 33 matching single-cycle writes -> finish=1, error_num=0, fail_valid=0, duration equals cycles spent in CHECK.
REQ-029 Same run with the write at index 5 carrying 99 (expected 5), stop_on_err=0 -> finish after 33 writes, error_num=1, fail_idx=5.
REQ-030 Same mismatch with stop_on_err=1 -> REPORT in the cycle after the write at index 5, error_num=1, index frozen at 6.
REQ-031 wen held high 4 cycles per write (stalled bus) and writes to 0x44 interleaved -> each held write counted once, 0x44 writes ignored, error_num=0.
REQ-032 rst asserted mid-CHECK, then clear asserted in REPORT -> outputs return to REQ-026 values immediately (rst) or next cycle (clear); a fresh BEGIN_SYM starts a new run.
REQ-033 With RESULT_MONITOR_TIMEOUT_EN and TIMEOUT=100, begin a run then stop writing -> timeout=1 and finish=1 after 100 CHECK cycles; without the macro, timeout stays 0 and busy stays 1.
